// File: rtl/ascii_bcd_packer.sv
// ascii_bcd_packer
//   Takes a stream of ASCII decimal characters and packs each number into a
//   right-aligned, zero-padded packed-BCD word for the BCD-to-binary
//   converter. Slot 0 (bits [3:0]) holds the most significant digit. One word
//   is emitted per number; in_last marks the final beat of a number.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both high. A producer holding valid keeps its data stable until
//   that edge. ready never depends on valid in the same cycle.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready       input beat handshake
//   in_char                 ASCII character of this beat
//   in_last                 this beat ends the current number
//   out_valid/out_ready     packed-word handshake
//   out_bcd                 packed BCD, slot k = bits [4k+3:4k], slot 0 = MSD
//   out_ndigits             number of digits captured (0..NUM_DIGITS)
//   out_err                 [0] bad character, [1] overflow, [2] empty number
//   state_dbg               current FSM state, 0 = COLLECT, 1 = HOLD (debug only)
module ascii_bcd_packer #(
    parameter int NUM_DIGITS = 300,
    parameter int CNT_W      = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_char,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [CNT_W-1:0]        out_ndigits,
    output logic [2:0]              out_err,
    output logic                    state_dbg
);

    localparam int                W       = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_DIGITS);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state_q, state_nxt;
    logic [W-1:0]     shift_q, shift_nxt;
    logic [CNT_W-1:0] cnt_q,   cnt_nxt;
    logic [2:0]       err_q,   err_nxt;
    logic             is_digit;
    logic             load_out;

    assign is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
    assign state_dbg = state_q;

    always_comb begin
        state_nxt = state_q;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_out  = 1'b0;

        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_digit) begin
                        // After a bad char or overflow the number is already
                        // flagged; later digits are dropped so the word shows
                        // what was captured before the first error.
                        if (err_q[1:0] == 2'b00) begin
                            if (cnt_q < MAX_CNT) begin
                                // Shift toward slot 0 so the newest digit
                                // always lands in slot N-1 (right-aligned).
                                shift_nxt = {in_char[3:0], shift_q[W-1:4]};
                                cnt_nxt   = cnt_q + CNT_W'(1);
                            end else begin
                                err_nxt[1] = 1'b1;
                            end
                        end
                    end else begin
                        err_nxt[0] = 1'b1;
                    end

                    // The last beat's character is processed first, so the
                    // empty check sees the final count.
                    if (in_last) begin
                        if (cnt_nxt == '0) begin
                            err_nxt[2] = 1'b1;
                        end
                        load_out  = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                    err_nxt   = '0;
                    state_nxt = COLLECT;
                end
            end

            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
            shift_q <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_nxt;
            shift_q <= shift_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
        end
    end

    // Output word is a separate register so it keeps the last emitted
    // values while the next number is being collected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_bcd     <= '0;
            out_ndigits <= '0;
            out_err     <= '0;
        end else if (load_out) begin
            out_bcd     <= shift_nxt;
            out_ndigits <= cnt_nxt;
            out_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ascii_bcd_packer.sv
// tb_ascii_bcd_packer
//   Directed bench for ascii_bcd_packer. Instance a uses NUM_DIGITS=4 for
//   overflow, bad-character, empty, back-pressure and reset cases; instance b
//   uses NUM_DIGITS=300 for the full-width alignment case. Expected words are
//   hand computed and queued as {bcd[15:0], ndigits[2:0], err[2:0]}.
module tb_ascii_bcd_packer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- instance a: NUM_DIGITS = 4 ----------------
    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
    logic [7:0]  a_in_char;
    logic [15:0] a_out_bcd;
    logic [2:0]  a_out_ndigits, a_out_err;
    logic        a_state_dbg;

    ascii_bcd_packer #(.NUM_DIGITS(4), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_char(a_in_char), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bcd(a_out_bcd), .out_ndigits(a_out_ndigits), .out_err(a_out_err),
        .state_dbg(a_state_dbg)
    );

    // ---------------- instance b: NUM_DIGITS = 300 ----------------
    logic          b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
    logic [7:0]    b_in_char;
    logic [1199:0] b_out_bcd;
    logic [8:0]    b_out_ndigits;
    logic [2:0]    b_out_err;
    logic          b_state_dbg;

    ascii_bcd_packer #(.NUM_DIGITS(300), .CNT_W(9)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_char(b_in_char), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bcd(b_out_bcd), .out_ndigits(b_out_ndigits), .out_err(b_out_err),
        .state_dbg(b_state_dbg)
    );

    // ---------------- scoreboard ----------------
    int          vectors     = 0;
    int          miscompares = 0;
    logic [21:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks (start and end on a negedge) ----------------
    task automatic a_send(input logic [7:0] c, input logic last, input int max_gap);
        int n;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        a_in_valid = 1'b1;
        a_in_char  = c;
        a_in_last  = last;
        n = 0;
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("a_in_ready_timeout", 0, 1);
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        a_in_char  = 8'h00;
    endtask

    task automatic a_number(input string s, input logic [21:0] exp, input int max_gap);
        exp_q.push_back(exp);
        for (int i = 0; i < s.len(); i++) begin
            a_send(s[i], (i == s.len() - 1), max_gap);
        end
    endtask

    // Called right after the last beat: out_valid must already be high.
    task automatic a_recv(input int hold_cycles);
        logic [21:0] e;
        int          n;
        n = 0;
        while (!a_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("a_latency", n, 0);
        if (exp_q.size() == 0) begin
            check_val("a_sb_underflow", 1, 0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check_val("a_bcd", a_out_bcd, e[21:6]);
        check_val("a_ndigits", a_out_ndigits, e[5:3]);
        check_val("a_err", a_out_err, e[2:0]);
        check_val("a_hold_in_ready", a_in_ready, 0);
        // A pending beat offered during HOLD must not be taken.
        a_in_valid = 1'b1;
        a_in_char  = "5";
        a_in_last  = 1'b1;
        repeat (hold_cycles) begin
            @(negedge clk);
            check_val("a_bp_in_ready", a_in_ready, 0);
            check_val("a_bp_out_valid", a_out_valid, 1);
            check_val("a_bp_bcd", a_out_bcd, e[21:6]);
            check_val("a_bp_ndigits", a_out_ndigits, e[5:3]);
            check_val("a_bp_err", a_out_err, e[2:0]);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        a_in_last   = 1'b0;
        a_in_char   = 8'h00;
        check_val("a_rel_out_valid", a_out_valid, 0);
        check_val("a_rel_in_ready", a_in_ready, 1);
        check_val("a_rel_bcd_kept", a_out_bcd, e[21:6]);
    endtask

    task automatic b_send(input logic [7:0] c, input logic last);
        int n;
        b_in_valid = 1'b1;
        b_in_char  = c;
        b_in_last  = last;
        n = 0;
        while (!b_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("b_in_ready_timeout", 0, 1);
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        b_in_char  = 8'h00;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        a_in_valid  = 1'b0; a_in_char = 8'h00; a_in_last = 1'b0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_char = 8'h00; b_in_last = 1'b0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_val("rst_a_out_valid", a_out_valid, 0);
        check_val("rst_a_in_ready", a_in_ready, 1);
        check_val("rst_a_bcd", a_out_bcd, 0);
        check_val("rst_a_ndigits", a_out_ndigits, 0);
        check_val("rst_a_err", a_out_err, 0);
        check_val("rst_a_state", a_state_dbg, 0);
        check_val("rst_b_out_valid", b_out_valid, 0);
        check_val("rst_b_in_ready", b_in_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // N=300: "123" lands in slots 297..299, everything above is zero
        b_send("1", 1'b0);
        b_send("2", 1'b0);
        b_send("3", 1'b1);
        check_val("b_latency", b_out_valid, 1);
        check_val("b_state", b_state_dbg, 1);
        check_val("b_top_slots", b_out_bcd[1199:1188], 12'h321);
        check_val("b_low_slots_zero", |b_out_bcd[1187:0], 0);
        check_val("b_ndigits", b_out_ndigits, 3);
        check_val("b_err", b_out_err, 0);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check_val("b_rel_in_ready", b_in_ready, 1);
        check_val("b_rel_out_valid", b_out_valid, 0);

        // N=4 directed numbers, expected {bcd, ndigits, err}
        a_number("98765", {16'h6789, 3'd4, 3'b010}, 0);  a_recv(0);
        a_number("1x2",   {16'h1000, 3'd1, 3'b001}, 0);  a_recv(0);
        a_number(" ",     {16'h0000, 3'd0, 3'b101}, 0);  a_recv(0);
        a_number("0",     {16'h0000, 3'd1, 3'b000}, 0);  a_recv(0);
        a_number("1234",  {16'h4321, 3'd4, 3'b000}, 0);  a_recv(0);
        a_number("12345a",{16'h4321, 3'd4, 3'b011}, 0);  a_recv(0);
        // Random in_valid gaps plus 5 cycles of back-pressure
        a_number("42",    {16'h2400, 3'd2, 3'b000}, 3);  a_recv(5);
        a_number("7a8",   {16'h7000, 3'd1, 3'b001}, 3);  a_recv(2);
        a_number("057",   {16'h7500, 3'd3, 3'b000}, 3);  a_recv(0);

        // Reset in the middle of a number, with a beat on the bus
        a_send("1", 1'b0, 0);
        a_send("2", 1'b0, 0);
        a_in_valid = 1'b1;
        a_in_char  = "3";
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_out_valid", a_out_valid, 0);
        check_val("mid_rst_in_ready", a_in_ready, 1);
        check_val("mid_rst_bcd", a_out_bcd, 0);
        check_val("mid_rst_ndigits", a_out_ndigits, 0);
        @(negedge clk);
        reset      = 1'b0;
        a_in_valid = 1'b0;
        a_in_char  = 8'h00;
        @(negedge clk);
        a_number("4", {16'h4000, 3'd1, 3'b000}, 0);  a_recv(0);

        check_val("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
